// File: rtl/fir_fifo_writer.sv
`default_nettype none
// ============================================================================
//  Module      : fir_fifo_writer
//  Description : Producer-side controller for the FIR core's input FIFO.
//                Buffers upstream samples in a small circular skid buffer,
//                drives the core's write/input_data pins while honouring
//                full, and on request appends FLUSH_LEN zero samples so the
//                last real samples are pushed through every tap.
//  Ports       : clk2         - write-side clock (rising edge)
//                reset        - asynchronous active-low reset
//                in_data/in_valid/in_ready - upstream valid/ready sample port
//                flush_req    - single-cycle request for a zero-fill flush
//                full         - FIFO full flag from the core
//                write/input_data - FIFO write strobe and data to the core
//                busy         - controller not idle (flushing or holding data)
//                flush_done   - one-cycle pulse after the last flush zero
//                sample_count - number of real samples written (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_fifo_writer #(
    parameter int DEPTH     = 4,
    parameter int FLUSH_LEN = 64
) (
    input  logic        clk2,
    input  logic        reset,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush_req,
    input  logic        full,
    output logic        write,
    output logic [15:0] input_data,
    output logic        busy,
    output logic        flush_done,
    output logic [31:0] sample_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         zcnt_q, zcnt_d;
    logic [31:0]        sample_count_q, sample_count_d;
    logic               flush_done_q, flush_done_d;

    logic [15:0]        buf_q [DEPTH];

    logic               push;
    logic               real_wr;
    logic               zero_wr;

    // Upstream handshake. Gating with reset keeps in_ready low while the
    // block is held in reset and lets it rise as soon as reset is released.
    assign in_ready = reset & (state_q == ST_RUN) & (count_q < CNT_W'(DEPTH));
    assign push     = in_valid & in_ready;

    // Real samples are written from the head entry in RUN and DRAIN; zeros
    // in FLUSH. Both are gated on full combinationally so no write is ever
    // issued while the core's FIFO is full.
    assign real_wr  = (state_q != ST_FLUSH) & (count_q != '0) & ~full;
    assign zero_wr  = (state_q == ST_FLUSH) & ~full;
    assign write    = real_wr | zero_wr;

    // An empty buffer presents zero rather than a stale or uninitialised entry.
    assign input_data = ((state_q == ST_FLUSH) || (count_q == '0)) ? 16'h0000
                                                                   : buf_q[rd_ptr_q];

    assign busy         = (state_q != ST_RUN) | (count_q != '0);
    assign flush_done   = flush_done_q;
    assign sample_count = sample_count_q;

    // Buffer storage: data only, no reset needed since occupancy guards it.
    always_ff @(posedge clk2) begin
        if (push) begin
            buf_q[wr_ptr_q] <= in_data;
        end
    end

    always_comb begin
        state_d        = state_q;
        zcnt_d         = zcnt_q;
        flush_done_d   = 1'b0;
        // DEPTH is a power of two, so the pointers wrap naturally.
        rd_ptr_d       = rd_ptr_q + PTR_W'(real_wr);
        wr_ptr_d       = wr_ptr_q + PTR_W'(push);
        count_d        = count_q + CNT_W'(push) - CNT_W'(real_wr);
        sample_count_d = sample_count_q + 32'(real_wr);

        unique case (state_q)
            ST_RUN: begin
                if (flush_req) begin
                    // A push in the request cycle still lands in the buffer,
                    // so it must be drained before the zero fill starts.
                    if ((count_q == '0) && !push) begin
                        state_d = ST_FLUSH;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (count_d == '0) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (zero_wr) begin
                    if (zcnt_q == 8'(FLUSH_LEN - 1)) begin
                        zcnt_d       = 8'd0;
                        state_d      = ST_RUN;
                        flush_done_d = 1'b1;
                    end else begin
                        zcnt_d = zcnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_RUN;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            zcnt_q         <= 8'd0;
            sample_count_q <= 32'd0;
            flush_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            zcnt_q         <= zcnt_d;
            sample_count_q <= sample_count_d;
            flush_done_q   <= flush_done_d;
        end
    end

endmodule
`default_nettype wire
